btn_conditioner: RTL and testbench
==================================

BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, stable cycles required to accept a level change (legal >= 1).
REQ-002 SHALL have parameter REPEAT_DELAY, default 50000000, cycles from press pulse to first repeat pulse (legal >= 2).
REQ-003 SHALL have parameter REPEAT_PERIOD, default 10000000, cycles between later repeat pulses (legal >= 1).
REQ-004 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port btn_i  input  4  raw asynchronous push-button levels, 1 = pressed.
REQ-007 SHALL have port btn_o  output  4  per-button one-cycle press (and repeat) pulses, consumed by the calculator controller.
REQ-008 SHALL have port btn_lvl_o  output  4  per-button debounced level.

Function
REQ-009 SHALL pass each btn_i bit through a 2-flop synchronizer before any other use.
REQ-010 SHALL keep per button a stable level, a debounce counter of width $clog2(DEBOUNCE_CYCLES)+1, and a repeat counter sized for max(REPEAT_DELAY, REPEAT_PERIOD).
REQ-011 SHALL clear the debounce counter on every cycle where the synchronized input equals the stable level.
REQ-012 SHALL, while the synchronized input differs from the stable level, toggle the stable level and clear the counter when the counter equals DEBOUNCE_CYCLES-1; otherwise increment the counter.
REQ-013 SHALL ignore any synchronized glitch shorter than DEBOUNCE_CYCLES cycles; the counter restarts from 0 on each bounce.
REQ-014 SHALL have this latency: if edge k is the first to sample btn_i[i] high and the input stays high, btn_lvl_o[i] and btn_o[i] rise after edge k+1+DEBOUNCE_CYCLES.
REQ-015 SHALL drive btn_o[i] high for exactly one cycle on the cycle btn_lvl_o[i] goes 0->1, with no pulse on release.
REQ-016 SHALL process all four buttons independently; simultaneous presses yield simultaneous pulses in the same cycle.
REQ-017 SHALL drive btn_lvl_o directly from the stable level registers and btn_o from registers, with no combinational path from btn_i.

Reset
REQ-018 SHALL, while rst = 1 at a clock edge, clear the synchronizers, stable levels, all counters, btn_o and btn_lvl_o to 0.
REQ-019 SHALL, on reset asserted mid-debounce or mid-repeat, abandon the operation with no pulse in the following cycle.
REQ-020 SHALL treat a button held through reset release as a new press: one pulse per REQ-014, counting from the first post-reset edge.

Configuration
REQ-021 SHALL include auto-repeat only when macro BTN_AUTOREPEAT_EN is defined.
REQ-022 SHALL, with BTN_AUTOREPEAT_EN defined, emit further btn_o[i] pulses while btn_lvl_o[i] stays 1, at cycles P+REPEAT_DELAY and P+REPEAT_DELAY+n*REPEAT_PERIOD (n >= 1), where P is the press-pulse cycle.
REQ-023 SHALL, with BTN_AUTOREPEAT_EN defined, stop repeating and clear the repeat counter in the cycle btn_lvl_o[i] falls.
REQ-024 SHALL, without BTN_AUTOREPEAT_EN, omit the repeat counters and emit exactly one pulse per debounced press; REPEAT_DELAY and REPEAT_PERIOD are then unused.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5)
REQ-025 SHALL cover clean press: btn_i=0001 first sampled at edge 10 and held -> btn_lvl_o[0]=1 and btn_o=0001 after edge 15, then btn_o=0000 after edge 16.
REQ-026 SHALL cover bounce: btn_i[1] toggles 1,0,1,0 each cycle, then holds 1 -> no pulse during bounce; exactly one pulse 5 cycles after the first edge of the final stable 1.
REQ-027 SHALL cover glitch: btn_i[2]=1 for 3 cycles, then 0 -> btn_lvl_o and btn_o stay 0.
REQ-028 SHALL cover simultaneous press: btn_i=1111 in one cycle -> btn_o=1111 for one cycle; release -> no pulse; btn_lvl_o=0000 five cycles after the release is first sampled.
REQ-029 SHALL cover reset mid-debounce: rst=1 two cycles into debounce of btn_i[3] while the button is held -> all outputs 0; after rst falls, one pulse 5 cycles after the first post-reset edge.
REQ-030 SHALL cover auto-repeat with BTN_AUTOREPEAT_EN defined: btn_i[0] held 40 cycles after the press pulse at P -> pulses at P, P+10, P+15, P+20, ... up to release; with the macro undefined -> single pulse at P only.

Source files
------------

// File: rtl/btn_conditioner.sv
// btn_conditioner: four push-button conditioner.
// Each button goes through a 2-flop synchronizer and a stable-level debouncer.
// Outputs are the debounced level and a one-cycle pulse on each debounced press.
// Auto-repeat is included only when BTN_AUTOREPEAT_EN is defined. Otherwise
// REPEAT_DELAY and REPEAT_PERIOD take part only in the configuration check.
module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_i,
  output logic [3:0] btn_o,
  output logic [3:0] btn_lvl_o
);

  localparam int unsigned NB = 4;
  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES) + 1;
  // An illegal configuration keeps the block in reset.
  localparam bit CFG_OK = (DEBOUNCE_CYCLES >= 1) && (REPEAT_DELAY >= 2) &&
                          (REPEAT_PERIOD >= 1);

  logic          rst_eff;
  logic [NB-1:0] sync1_q;
  logic [NB-1:0] sync2_q;
  logic [NB-1:0] stable_q;
  logic [NB-1:0] stable_d;
  logic [DW-1:0] db_cnt_q [NB];
  logic [DW-1:0] db_cnt_d [NB];
  logic [NB-1:0] pulse_q;
  logic [NB-1:0] pulse_d;

  assign rst_eff = rst || !CFG_OK;

  // Two-flop synchronizer for the raw button levels.
  always_ff @(posedge clk) begin
    if (rst_eff) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: the stable level flips after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    stable_d = stable_q;
    for (int unsigned i = 0; i < NB; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          stable_d[i] = ~stable_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DW'(1);
        end
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk) begin
    if (rst_eff) begin
      stable_q <= '0;
      for (int unsigned i = 0; i < NB; i++) db_cnt_q[i] <= '0;
    end else begin
      stable_q <= stable_d;
      for (int unsigned i = 0; i < NB; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW      = $clog2(RPT_MAX) + 1;

  logic [RW-1:0] rpt_cnt_q [NB];
  logic [RW-1:0] rpt_cnt_d [NB];
  logic [NB-1:0] rpt_later_q;
  logic [NB-1:0] rpt_later_d;
  logic [NB-1:0] rpt_fire;

  // Repeat timer: the first repeat comes REPEAT_DELAY after the press, later ones every REPEAT_PERIOD.
  always_comb begin
    rpt_later_d = rpt_later_q;
    rpt_fire    = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      rpt_cnt_d[i] = rpt_cnt_q[i] + RW'(1);
      if (!(stable_q[i] && stable_d[i])) begin
        // Idle, the press cycle itself, or release: the timer restarts.
        rpt_cnt_d[i]   = '0;
        rpt_later_d[i] = 1'b0;
      end else if (!rpt_later_q[i] && rpt_cnt_q[i] == RW'(REPEAT_DELAY - 1)) begin
        rpt_fire[i]    = 1'b1;
        rpt_cnt_d[i]   = '0;
        rpt_later_d[i] = 1'b1;
      end else if (rpt_later_q[i] && rpt_cnt_q[i] == RW'(REPEAT_PERIOD - 1)) begin
        rpt_fire[i]    = 1'b1;
        rpt_cnt_d[i]   = '0;
      end
    end
  end

  // Repeat state registers.
  always_ff @(posedge clk) begin
    if (rst_eff) begin
      rpt_later_q <= '0;
      for (int unsigned i = 0; i < NB; i++) rpt_cnt_q[i] <= '0;
    end else begin
      rpt_later_q <= rpt_later_d;
      for (int unsigned i = 0; i < NB; i++) rpt_cnt_q[i] <= rpt_cnt_d[i];
    end
  end

  // Pulse on each debounced rising level, plus repeats.
  always_comb begin
    pulse_d = (stable_d & ~stable_q) | rpt_fire;
  end
`else
  // Pulse on each debounced rising level only.
  always_comb begin
    pulse_d = stable_d & ~stable_q;
  end
`endif

  // Registered pulse output.
  always_ff @(posedge clk) begin
    if (rst_eff) begin
      pulse_q <= '0;
    end else begin
      pulse_q <= pulse_d;
    end
  end

  assign btn_o     = pulse_q;
  assign btn_lvl_o = stable_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed scenarios with literal expectations,
// then randomized stimulus checked each cycle against a sample-window model.
module tb_btn_conditioner;

  localparam int unsigned DB = 4;
  localparam int unsigned RD = 10;
  localparam int unsigned RP = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn_i = 4'b0000;
  logic [3:0] btn_o;
  logic [3:0] btn_lvl_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_i    (btn_i),
    .btn_o    (btn_o),
    .btn_lvl_o(btn_lvl_o)
  );

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model. A level flips once the last DB synchronized samples all
  // differ from it. The synchronized sample seen at an edge is btn_i from two
  // edges earlier; samples from before reset count as 0.
  bit [3:0]   m_lvl;
  bit [3:0]   m_pulse;
  bit         m_valid = 1'b0;
  logic [3:0] samples[$];
  int         m_edge;
  int         press_edge[4];

  always @(posedge clk) begin : model
    bit [3:0] nl;
    bit [3:0] rise;
    bit [3:0] rep;
    bit       diff_all;
    bit       v;
    if (rst) begin
      m_valid = 1'b1;
      m_lvl   = '0;
      m_pulse = '0;
      m_edge  = 0;
      samples.delete();
    end else begin
      samples.push_front(btn_i);
      if (samples.size() > int'(DB) + 2) void'(samples.pop_back());
      for (int i = 0; i < 4; i++) begin
        diff_all = 1'b1;
        for (int j = 0; j < int'(DB); j++) begin
          v = (j + 2 < samples.size()) ? samples[j + 2][i] : 1'b0;
          if (v == m_lvl[i]) diff_all = 1'b0;
        end
        nl[i] = diff_all ? ~m_lvl[i] : m_lvl[i];
      end
      rise = nl & ~m_lvl;
      rep  = '0;
      for (int i = 0; i < 4; i++) begin
        if (rise[i]) press_edge[i] = m_edge;
`ifdef BTN_AUTOREPEAT_EN
        if (m_lvl[i] && nl[i] && (m_edge - press_edge[i]) >= int'(RD) &&
            ((m_edge - press_edge[i] - int'(RD)) % int'(RP)) == 0)
          rep[i] = 1'b1;
`endif
      end
      m_pulse = rise | rep;
      m_lvl   = nl;
      m_edge++;
    end
  end

  // Compare the DUT outputs with the model every cycle.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_pulse", btn_o, m_pulse);
      chk("model_level", btn_lvl_o, m_lvl);
    end
  end

  function automatic logic [3:0] rep_exp(input int t);
`ifdef BTN_AUTOREPEAT_EN
    return (t >= int'(RD) && ((t - int'(RD)) % int'(RP)) == 0) ? 4'b0001 : 4'b0000;
`else
    return (t == 0) ? 4'b0001 : 4'b0000;
`endif
  endfunction

  initial begin
    rst   = 1'b1;
    btn_i = 4'b0000;
    step(3);
    chk("reset_pulse", btn_o, 4'b0000);
    chk("reset_level", btn_lvl_o, 4'b0000);
    rst = 1'b0;
    step(3);

    // Clean press on button 0.
    btn_i = 4'b0001;
    step(5);
    chk("clean_pre_level", btn_lvl_o, 4'b0000);
    chk("clean_pre_pulse", btn_o, 4'b0000);
    step(1);
    chk("clean_level", btn_lvl_o, 4'b0001);
    chk("clean_pulse", btn_o, 4'b0001);
    step(1);
    chk("clean_pulse_end", btn_o, 4'b0000);
    btn_i = 4'b0000;
    step(5);
    chk("clean_rel_hold", btn_lvl_o, 4'b0001);
    step(1);
    chk("clean_rel_level", btn_lvl_o, 4'b0000);
    chk("clean_rel_pulse", btn_o, 4'b0000);
    step(4);

    // Bounce on button 1, then a stable press.
    for (int b = 0; b < 4; b++) begin
      btn_i = (b % 2 == 0) ? 4'b0010 : 4'b0000;
      step(1);
      chk("bounce_quiet", btn_o, 4'b0000);
    end
    btn_i = 4'b0010;
    step(5);
    chk("bounce_pre_pulse", btn_o, 4'b0000);
    step(1);
    chk("bounce_pulse", btn_o, 4'b0010);
    step(1);
    chk("bounce_pulse_end", btn_o, 4'b0000);
    btn_i = 4'b0000;
    step(10);

    // Short glitch on button 2.
    btn_i = 4'b0100;
    step(3);
    btn_i = 4'b0000;
    for (int t = 0; t < 8; t++) begin
      step(1);
      chk("glitch_pulse", btn_o, 4'b0000);
      chk("glitch_level", btn_lvl_o, 4'b0000);
    end

    // Simultaneous press and release of all buttons.
    btn_i = 4'b1111;
    step(6);
    chk("all_pulse", btn_o, 4'b1111);
    step(1);
    chk("all_pulse_end", btn_o, 4'b0000);
    chk("all_level", btn_lvl_o, 4'b1111);
    btn_i = 4'b0000;
    step(5);
    chk("all_rel_hold", btn_lvl_o, 4'b1111);
    step(1);
    chk("all_rel_level", btn_lvl_o, 4'b0000);
    chk("all_rel_pulse", btn_o, 4'b0000);
    step(4);

    // Reset mid-debounce on button 3, held through reset release.
    btn_i = 4'b1000;
    step(3);
    rst = 1'b1;
    step(1);
    chk("rst_mid_pulse", btn_o, 4'b0000);
    step(1);
    chk("rst_mid_level", btn_lvl_o, 4'b0000);
    rst = 1'b0;
    step(5);
    chk("rst_post_pre", btn_o, 4'b0000);
    step(1);
    chk("rst_post_pulse", btn_o, 4'b1000);
    step(1);
    chk("rst_post_end", btn_o, 4'b0000);
    btn_i = 4'b0000;
    step(10);

    // Long hold on button 0: repeats only with auto-repeat built in.
    btn_i = 4'b0001;
    step(6);
    chk("hold_press", btn_o, rep_exp(0));
    for (int t = 1; t <= 40; t++) begin
      step(1);
      chk("hold_repeat", btn_o, rep_exp(t));
    end
    btn_i = 4'b0000;
    step(10);

    // Randomized stimulus, checked by the model.
    for (int s = 0; s < 300; s++) begin
      logic [3:0] flip;
      int         hold;
      flip  = 4'($urandom_range(0, 15));
      hold  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(15, 40)) : int'($urandom_range(1, 6));
      btn_i = btn_i ^ flip;
      if ($urandom_range(0, 40) == 0) begin
        rst = 1'b1;
        step(int'($urandom_range(1, 3)));
        rst = 1'b0;
      end
      step(hold);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
